// File: rtl/di_hall_decoder.sv
// Hall sensor decoder: synchronises and filters three Hall inputs, tracks the
// 6-step commutation sequence and reports direction, position, step period and errors.
module di_hall_decoder #(
    parameter int          FILT_CLKS  = 8,
    parameter logic [31:0] STALL_CLKS = 32'd75000000
) (
    input  logic        xclk,
    input  logic        reset,
    input  logic        hall_a_in,
    input  logic        hall_b_in,
    input  logic        hall_c_in,
    input  logic        hall_phase,
    input  logic        clear_status,
    output logic [2:0]  hall_state,
    output logic        hall_dir,
    output logic [15:0] position,
    output logic        edge_strobe,
    output logic [31:0] edge_period,
    output logic        period_valid,
    output logic        illegal_err,
    output logic        skip_err,
    output logic        stall
);

    localparam int             FW   = (FILT_CLKS > 1) ? $clog2(FILT_CLKS) : 1;
    localparam logic [FW-1:0]  FMAX = FW'(FILT_CLKS - 1);

    // Forward successor of a code; illegal codes map to themselves.
    function automatic logic [2:0] fwd_next(input logic [2:0] c, input logic ph);
        logic [2:0] n;
        n = c;
        if (ph) begin
            case (c)
                3'b100:  n = 3'b110;
                3'b110:  n = 3'b010;
                3'b010:  n = 3'b011;
                3'b011:  n = 3'b001;
                3'b001:  n = 3'b101;
                3'b101:  n = 3'b100;
                default: n = c;
            endcase
        end else begin
            case (c)
                3'b000:  n = 3'b100;
                3'b100:  n = 3'b110;
                3'b110:  n = 3'b111;
                3'b111:  n = 3'b011;
                3'b011:  n = 3'b001;
                3'b001:  n = 3'b000;
                default: n = c;
            endcase
        end
        return n;
    endfunction

    function automatic logic is_illegal(input logic [2:0] c, input logic ph);
        return ph ? (c == 3'b000 || c == 3'b111) : (c == 3'b010 || c == 3'b101);
    endfunction

    logic [2:0]  sync1_q, sync2_q, cand_q, cand_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic        phase_q, init_q, init_d, prev_valid_q, prev_valid_d;
    logic [31:0] period_cnt_q, period_cnt_d;
    logic [2:0]  hall_state_q, hall_state_d;
    logic        hall_dir_q, hall_dir_d, edge_strobe_q, edge_strobe_d;
    logic [15:0] position_q, position_d, pos_base;
    logic [31:0] edge_period_q, edge_period_d;
    logic        period_valid_q, period_valid_d, illegal_q, illegal_d;
    logic        skip_q, skip_d, stall_q, stall_d;
    logic        accept, toggle, is_fwd, is_rev;

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            sync1_q        <= 3'b000;
            sync2_q        <= 3'b000;
            cand_q         <= 3'b000;
            fcnt_q         <= '0;
            phase_q        <= 1'b0;
            init_q         <= 1'b1;
            prev_valid_q   <= 1'b0;
            period_cnt_q   <= 32'd0;
            hall_state_q   <= 3'b000;
            hall_dir_q     <= 1'b0;
            edge_strobe_q  <= 1'b0;
            position_q     <= 16'd0;
            edge_period_q  <= 32'd0;
            period_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            skip_q         <= 1'b0;
            stall_q        <= 1'b0;
        end else begin
            sync1_q        <= {hall_a_in, hall_b_in, hall_c_in};
            sync2_q        <= sync1_q;
            cand_q         <= cand_d;
            fcnt_q         <= fcnt_d;
            phase_q        <= hall_phase;
            init_q         <= init_d;
            prev_valid_q   <= prev_valid_d;
            period_cnt_q   <= period_cnt_d;
            hall_state_q   <= hall_state_d;
            hall_dir_q     <= hall_dir_d;
            edge_strobe_q  <= edge_strobe_d;
            position_q     <= position_d;
            edge_period_q  <= edge_period_d;
            period_valid_q <= period_valid_d;
            illegal_q      <= illegal_d;
            skip_q         <= skip_d;
            stall_q        <= stall_d;
        end
    end

    // Filter: a code must be stable for FILT_CLKS synced samples to be accepted.
    always_comb begin
        cand_d = cand_q;
        fcnt_d = fcnt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            fcnt_d = '0;
        end else if (fcnt_q != FMAX) begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign accept   = (fcnt_q == FMAX) && (cand_q != hall_state_q);
    assign toggle   = (hall_phase != phase_q);
    assign is_fwd   = (fwd_next(hall_state_q, hall_phase) == cand_q);
    assign is_rev   = !is_illegal(cand_q, hall_phase) && (fwd_next(cand_q, hall_phase) == hall_state_q);
    assign pos_base = clear_status ? 16'd0 : position_q;

    // Classification; later assignments win, so error sets override clear_status.
    always_comb begin
        init_d         = init_q;
        prev_valid_d   = prev_valid_q;
        hall_state_d   = hall_state_q;
        hall_dir_d     = hall_dir_q;
        edge_strobe_d  = 1'b0;
        position_d     = pos_base;
        edge_period_d  = edge_period_q;
        period_valid_d = period_valid_q;
        illegal_d      = clear_status ? 1'b0 : illegal_q;
        skip_d         = clear_status ? 1'b0 : skip_q;
        stall_d        = stall_q;
        period_cnt_d   = (period_cnt_q == 32'hFFFF_FFFF) ? period_cnt_q : period_cnt_q + 32'd1;
        if (period_cnt_q >= STALL_CLKS - 32'd1) begin
            stall_d        = 1'b1;
            period_valid_d = 1'b0;
        end
        if (toggle) begin
            init_d         = 1'b1;
            prev_valid_d   = 1'b0;
            period_valid_d = 1'b0;
        end
        if (accept) begin
            hall_state_d = cand_q;
            if (is_illegal(cand_q, hall_phase)) begin
                illegal_d    = 1'b1;
                init_d       = 1'b1;
                prev_valid_d = 1'b0;
            end else if (init_q || toggle) begin
                init_d       = 1'b0;
                prev_valid_d = 1'b0;
                period_cnt_d = 32'd0;
            end else if (is_fwd || is_rev) begin
                hall_dir_d    = is_fwd;
                position_d    = is_fwd ? pos_base + 16'd1 : pos_base - 16'd1;
                edge_strobe_d = 1'b1;
                if (!stall_q && prev_valid_q) begin
                    edge_period_d  = period_cnt_q + 32'd1;
                    period_valid_d = 1'b1;
                end
                period_cnt_d = 32'd0;
                stall_d      = 1'b0;
                prev_valid_d = 1'b1;
            end else begin
                skip_d       = 1'b1;
                prev_valid_d = 1'b0;
            end
        end
    end

    assign hall_state   = hall_state_q;
    assign hall_dir     = hall_dir_q;
    assign position     = position_q;
    assign edge_strobe  = edge_strobe_q;
    assign edge_period  = edge_period_q;
    assign period_valid = period_valid_q;
    assign illegal_err  = illegal_q;
    assign skip_err     = skip_q;
    assign stall        = stall_q;

endmodule

// File: tb/tb_di_hall_decoder.sv
// Directed bench for di_hall_decoder: table of Hall codes with hand-computed
// results, plus sequences for glitch, clear, stall and phase change.
module tb_di_hall_decoder;

    logic        xclk = 1'b0;
    logic        reset;
    logic        hall_a_in, hall_b_in, hall_c_in;
    logic        hall_phase;
    logic        clear_status;
    logic [2:0]  hall_state;
    logic        hall_dir;
    logic [15:0] position;
    logic        edge_strobe;
    logic [31:0] edge_period;
    logic        period_valid;
    logic        illegal_err;
    logic        skip_err;
    logic        stall;

    int checks = 0;
    int errors = 0;

    di_hall_decoder #(.FILT_CLKS(8), .STALL_CLKS(32'd1000)) dut (
        .xclk(xclk), .reset(reset),
        .hall_a_in(hall_a_in), .hall_b_in(hall_b_in), .hall_c_in(hall_c_in),
        .hall_phase(hall_phase), .clear_status(clear_status),
        .hall_state(hall_state), .hall_dir(hall_dir), .position(position),
        .edge_strobe(edge_strobe), .edge_period(edge_period),
        .period_valid(period_valid), .illegal_err(illegal_err),
        .skip_err(skip_err), .stall(stall)
    );

    always #5 xclk = ~xclk;

    typedef struct {
        logic [2:0]  code;
        int          hold;
        logic [2:0]  st;
        logic        dir;
        logic [15:0] pos;
        int          strobes;
        logic        ill;
        logic        sk;
        logic        pv;
        logic [31:0] ep;
        logic        stall;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic [2:0] code, input int hold, input logic [2:0] st,
                                input logic dir, input int pos, input int strobes,
                                input logic ill, input logic sk, input logic pv,
                                input int ep, input logic stl);
        vec_t v;
        v.code = code; v.hold = hold; v.st = st; v.dir = dir; v.pos = 16'(pos);
        v.strobes = strobes; v.ill = ill; v.sk = sk; v.pv = pv; v.ep = 32'(ep); v.stall = stl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] code);
        {hall_a_in, hall_b_in, hall_c_in} = code;
    endtask

    task automatic apply(input int i);
        int strobes;
        string tag;
        strobes = 0;
        drive(tbl[i].code);
        repeat (tbl[i].hold) begin
            @(negedge xclk);
            if (edge_strobe) strobes++;
        end
        tag = $sformatf("v%0d", i);
        chk({tag, "_state"},   32'(hall_state),   32'(tbl[i].st));
        chk({tag, "_dir"},     32'(hall_dir),     32'(tbl[i].dir));
        chk({tag, "_pos"},     32'(position),     32'(tbl[i].pos));
        chk({tag, "_strobes"}, 32'(strobes),      32'(tbl[i].strobes));
        chk({tag, "_illegal"}, 32'(illegal_err),  32'(tbl[i].ill));
        chk({tag, "_skip"},    32'(skip_err),     32'(tbl[i].sk));
        chk({tag, "_pvalid"},  32'(period_valid), 32'(tbl[i].pv));
        chk({tag, "_period"},  edge_period,       tbl[i].ep);
        chk({tag, "_stall"},   32'(stall),        32'(tbl[i].stall));
    endtask

    initial begin
        int strobes;
        //              code   hold  st     dir pos stb ill sk pv  ep   stall
        tbl[0]  = mk(3'b100, 250, 3'b100, 0, 0, 0, 0, 0, 0, 0,   0);
        tbl[1]  = mk(3'b110, 250, 3'b110, 1, 1, 1, 0, 0, 0, 0,   0);
        tbl[2]  = mk(3'b010, 250, 3'b010, 1, 2, 1, 0, 0, 1, 250, 0);
        tbl[3]  = mk(3'b011, 250, 3'b011, 1, 3, 1, 0, 0, 1, 250, 0);
        tbl[4]  = mk(3'b001, 250, 3'b001, 1, 4, 1, 0, 0, 1, 250, 0);
        tbl[5]  = mk(3'b101, 250, 3'b101, 1, 5, 1, 0, 0, 1, 250, 0);
        tbl[6]  = mk(3'b100, 250, 3'b100, 1, 6, 1, 0, 0, 1, 250, 0);
        tbl[7]  = mk(3'b110, 250, 3'b110, 1, 7, 1, 0, 0, 1, 250, 0);
        tbl[8]  = mk(3'b100, 250, 3'b100, 0, 6, 1, 0, 0, 1, 250, 0);
        tbl[9]  = mk(3'b101, 250, 3'b101, 0, 5, 1, 0, 0, 1, 250, 0);
        tbl[10] = mk(3'b100, 250, 3'b100, 1, 6, 1, 0, 0, 1, 250, 0);
        tbl[11] = mk(3'b000, 250, 3'b000, 1, 6, 0, 1, 0, 1, 250, 0);
        tbl[12] = mk(3'b110, 250, 3'b110, 1, 6, 0, 1, 0, 1, 250, 0);
        tbl[13] = mk(3'b100, 250, 3'b100, 0, 5, 1, 1, 0, 1, 250, 0);
        tbl[14] = mk(3'b010, 250, 3'b010, 0, 5, 0, 1, 1, 1, 250, 0);
        tbl[15] = mk(3'b011, 250, 3'b011, 1, 1, 1, 0, 0, 1, 250, 0);
        tbl[16] = mk(3'b001, 1010, 3'b001, 1, 2, 1, 0, 0, 1, 250, 0);
        tbl[17] = mk(3'b101, 300, 3'b101, 1, 3, 1, 0, 0, 0, 250, 0);
        tbl[18] = mk(3'b100, 250, 3'b100, 1, 4, 1, 0, 0, 1, 300, 0);
        // 60 degree phasing from here on
        tbl[19] = mk(3'b110, 250, 3'b110, 1, 4, 0, 0, 0, 0, 300, 0);
        tbl[20] = mk(3'b111, 250, 3'b111, 1, 5, 1, 0, 0, 0, 300, 0);
        tbl[21] = mk(3'b011, 250, 3'b011, 1, 6, 1, 0, 0, 1, 250, 0);
        tbl[22] = mk(3'b111, 250, 3'b111, 0, 5, 1, 0, 0, 1, 250, 0);
        tbl[23] = mk(3'b010, 250, 3'b010, 1, 1, 0, 1, 0, 1, 250, 0);

        reset = 1'b0;
        drive(3'b000);
        hall_phase   = 1'b1;
        clear_status = 1'b0;
        repeat (3) @(negedge xclk);
        chk("rst_state",  32'(hall_state),   32'd0);
        chk("rst_dir",    32'(hall_dir),     32'd0);
        chk("rst_pos",    32'(position),     32'd0);
        chk("rst_strobe", 32'(edge_strobe),  32'd0);
        chk("rst_period", edge_period,       32'd0);
        chk("rst_pvalid", 32'(period_valid), 32'd0);
        chk("rst_errs",   32'({illegal_err, skip_err, stall}), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge xclk);

        for (int i = 0; i <= 10; i++) apply(i);

        // short glitch to an illegal code must be filtered out
        strobes = 0;
        drive(3'b000);
        repeat (5) @(negedge xclk);
        drive(3'b100);
        repeat (245) begin
            @(negedge xclk);
            if (edge_strobe) strobes++;
        end
        chk("glitch_state",   32'(hall_state),  32'(3'b100));
        chk("glitch_illegal", 32'(illegal_err), 32'd0);
        chk("glitch_strobes", 32'(strobes),     32'd0);

        for (int i = 11; i <= 14; i++) apply(i);

        clear_status = 1'b1;
        @(negedge xclk);
        clear_status = 1'b0;
        @(negedge xclk);
        chk("clr_skip",    32'(skip_err),    32'd0);
        chk("clr_illegal", 32'(illegal_err), 32'd0);
        chk("clr_pos",     32'(position),    32'd0);

        for (int i = 15; i <= 16; i++) apply(i);

        // 1000 clocks after the last accepted step
        @(negedge xclk);
        chk("stall_set",    32'(stall),        32'd1);
        chk("stall_pvalid", 32'(period_valid), 32'd0);

        for (int i = 17; i <= 18; i++) apply(i);

        hall_phase = 1'b0;
        @(negedge xclk);
        @(negedge xclk);
        chk("phase_pvalid", 32'(period_valid), 32'd0);
        chk("phase_pos",    32'(position),     32'd4);

        for (int i = 19; i <= 22; i++) apply(i);

        // clear_status in the same clock as a forward step
        drive(3'b011);
        repeat (10) @(negedge xclk);
        chk("align_before", 32'(hall_state), 32'(3'b111));
        clear_status = 1'b1;
        @(negedge xclk);
        clear_status = 1'b0;
        chk("align_state",  32'(hall_state),  32'(3'b011));
        chk("align_pos",    32'(position),    32'd1);
        chk("align_strobe", 32'(edge_strobe), 32'd1);
        chk("align_period", edge_period,      32'd250);
        @(negedge xclk);
        chk("align_strobe_low", 32'(edge_strobe), 32'd0);
        repeat (238) @(negedge xclk);

        apply(23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
